// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the word-to-byte memory controller:
//   - state_t       : 2-bit controller state encoding
//   - LANE_W, LANES : byte-lane width and lanes per 32-bit word
//   - *_LAST_CNT    : final cnt value of each multi-cycle phase
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int LANE_W = 8;
   localparam int LANES  = 4;

   // READ needs one extra cycle: byte 3 arrives one cycle after its address.
   localparam logic [2:0] READ_LAST_CNT  = 3'd4;
   localparam logic [2:0] WRITE_LAST_CNT = 3'd3;
   // Last cnt at which READ still drives a new byte address.
   localparam logic [2:0] ADDR_LAST_CNT  = 3'd3;

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
//   Bridges 32-bit word requests onto a synchronous 8-bit byte memory.
//   A read walks the four byte addresses of the aligned word and assembles
//   the returned bytes little-endian; a write walks the same four addresses
//   strobing only the lanes selected by the mask.
//
//   Handshake: a request (ram_r_enable_i / ram_w_enable_i) is taken only on a
//   rising edge while the controller is idle; write wins over read. From the
//   accepting edge ram_busy_o is high for the whole transaction, followed by
//   exactly one cycle of ram_done_o. Requests seen while busy or done are
//   ignored, so a level held through done starts a new transaction only at
//   the following idle edge.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ram_r_enable_i      word read request
//   ram_w_enable_i      word write request
//   ram_w_mask_i[3:0]   byte-lane write mask (bit k = byte k)
//   ram_w_data_i[31:0]  write data (lane k = bits 8k+7:8k)
//   ram_addr_i[31:0]    request byte address (low two bits ignored)
//   ram_r_data_o[31:0]  assembled read word, held until the next read
//   ram_busy_o          high during READ and WRITE
//   ram_done_o          one-cycle completion pulse
//   mem_addr_o          byte address to the byte memory
//   mem_dout_o[7:0]     byte write data
//   mem_we_o            byte write strobe
//   mem_din_i[7:0]      byte read data, valid one cycle after its address
// ----------------------------------------------------------------------------
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int MEM_AW = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ram_r_enable_i,
   input  logic              ram_w_enable_i,
   input  logic [3:0]        ram_w_mask_i,
   input  logic [31:0]       ram_w_data_i,
   input  logic [31:0]       ram_addr_i,
   output logic [31:0]       ram_r_data_o,
   output logic              ram_busy_o,
   output logic              ram_done_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [7:0]        mem_dout_o,
   output logic              mem_we_o,
   input  logic [7:0]        mem_din_i
);

   state_t            r_state;
   logic [2:0]        r_cnt;
   logic [MEM_AW-1:0] r_base;
   logic [3:0]        r_mask;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_busy;
   logic              r_done;
   logic [MEM_AW-1:0] r_mem_addr;
   logic [7:0]        r_mem_dout;
   logic              r_mem_we;

   logic [MEM_AW-1:0] w_req_base;
   logic [2:0]        w_cnt_nxt;
   logic [2:0]        w_cnt_prev;
   logic [MEM_AW-1:0] w_addr_nxt;
   logic [7:0]        w_lane_nxt;
   logic              w_unused_addr;

   // Word-aligned base; address bits above the memory are dropped so all
   // address arithmetic wraps modulo 2^MEM_AW.
   assign w_req_base = {ram_addr_i[MEM_AW-1:2], 2'b00};

   // Outputs are registered, so each cycle loads the values for cnt+1.
   assign w_cnt_nxt  = r_cnt + 3'd1;
   assign w_cnt_prev = r_cnt - 3'd1;
   assign w_addr_nxt = r_base + MEM_AW'(w_cnt_nxt);
   assign w_lane_nxt = r_wdata[{w_cnt_nxt[1:0], 3'b000} +: LANE_W];

   // Only ram_addr_i[MEM_AW-1:2] takes part in addressing.
   assign w_unused_addr = &{1'b0, ram_addr_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 3'd0;
         r_base     <= '0;
         r_mask     <= 4'd0;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_addr <= '0;
         r_mem_dout <= 8'd0;
         r_mem_we   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (ram_w_enable_i) begin
                  // Write takes priority; a simultaneous read is dropped.
                  r_state    <= ST_WRITE;
                  r_cnt      <= 3'd0;
                  r_base     <= w_req_base;
                  r_mask     <= ram_w_mask_i;
                  r_wdata    <= ram_w_data_i;
                  r_busy     <= 1'b1;
                  r_mem_addr <= w_req_base;
                  r_mem_dout <= ram_w_data_i[LANE_W-1:0];
                  r_mem_we   <= ram_w_mask_i[0];
               end else if (ram_r_enable_i) begin
                  r_state    <= ST_READ;
                  r_cnt      <= 3'd0;
                  r_base     <= w_req_base;
                  r_busy     <= 1'b1;
                  r_mem_addr <= w_req_base;
                  r_mem_we   <= 1'b0;
               end
            end

            ST_READ: begin
               // Data on mem_din_i belongs to the address of the previous cycle.
               if (r_cnt != 3'd0) begin
                  r_rdata[{w_cnt_prev[1:0], 3'b000} +: LANE_W] <= mem_din_i;
               end
               if (r_cnt == READ_LAST_CNT) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (r_cnt < ADDR_LAST_CNT) begin
                     r_mem_addr <= w_addr_nxt;
                  end
               end
            end

            ST_WRITE: begin
               if (r_cnt == WRITE_LAST_CNT) begin
                  r_state  <= ST_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_mem_we <= 1'b0;
               end else begin
                  r_cnt      <= w_cnt_nxt;
                  r_mem_addr <= w_addr_nxt;
                  r_mem_dout <= w_lane_nxt;
                  r_mem_we   <= r_mask[w_cnt_nxt[1:0]];
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end

            default: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   assign ram_r_data_o = r_rdata;
   assign ram_busy_o   = r_busy;
   assign ram_done_o   = r_done;
   assign mem_addr_o   = r_mem_addr;
   assign mem_dout_o   = r_mem_dout;
   assign mem_we_o     = r_mem_we;

endmodule : mem_ctrl

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl
//   Drives word requests into mem_ctrl, which talks to a byte memory held in
//   this bench. A reference byte array is updated by word-level rules
//   (aligned base, masked lanes, little-endian assembly) and compared with
//   the memory the controller actually wrote, with the returned read words,
//   with the strobe stream and with the cycle timing.
// ----------------------------------------------------------------------------
module tb_mem_ctrl;

   localparam int AW    = 17;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          ram_r_enable_i;
   logic          ram_w_enable_i;
   logic [3:0]    ram_w_mask_i;
   logic [31:0]   ram_w_data_i;
   logic [31:0]   ram_addr_i;
   logic [31:0]   ram_r_data_o;
   logic          ram_busy_o;
   logic          ram_done_o;
   logic [AW-1:0] mem_addr_o;
   logic [7:0]    mem_dout_o;
   logic          mem_we_o;
   logic [7:0]    mem_din_i;

   mem_ctrl #(.MEM_AW(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ram_r_enable_i (ram_r_enable_i),
      .ram_w_enable_i (ram_w_enable_i),
      .ram_w_mask_i   (ram_w_mask_i),
      .ram_w_data_i   (ram_w_data_i),
      .ram_addr_i     (ram_addr_i),
      .ram_r_data_o   (ram_r_data_o),
      .ram_busy_o     (ram_busy_o),
      .ram_done_o     (ram_done_o),
      .mem_addr_o     (mem_addr_o),
      .mem_dout_o     (mem_dout_o),
      .mem_we_o       (mem_we_o),
      .mem_din_i      (mem_din_i)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- byte memory (device side) ----------------
   logic [7:0] mem     [DEPTH];
   logic [7:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_dout_o;
      mem_din_i <= mem[mem_addr_o];
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [AW+7:0] exp_q[$];      // expected strobes {addr, byte}
   logic [31:0]   exp_rdata;     // what ram_r_data_o should hold

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every strobe must be an expected one, in order, and only while busy.
   always @(negedge clk) begin
      if (rst_n && mem_we_o) begin
         check("we_while_busy", ram_busy_o, 1'b1);
         if (exp_q.size() == 0) begin
            check("strobe_extra", {mem_addr_o, mem_dout_o}, '1);
         end else begin
            check("strobe", {mem_addr_o, mem_dout_o}, exp_q.pop_front());
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [AW-1:0] base_of(input logic [31:0] a);
      return {a[AW-1:2], 2'b00};
   endfunction

   function automatic logic [31:0] ref_word(input logic [AW-1:0] b);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[b + AW'(i)];
      return w;
   endfunction

   task automatic compare_mem(input logic [AW-1:0] b);
      for (int i = 0; i < 4; i++)
         check("mem_byte", {b + AW'(i), mem[b + AW'(i)]}, {b + AW'(i), ref_mem[b + AW'(i)]});
   endtask

   // ---------------- driver ----------------
   task automatic idle_inputs();
      ram_r_enable_i = 1'b0;
      ram_w_enable_i = 1'b0;
      ram_w_mask_i   = 4'd0;
      ram_w_data_i   = 32'd0;
      ram_addr_i     = 32'd0;
   endtask

   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data);
      logic [AW-1:0] b;
      int done_at;
      int busy_n;
      b = base_of(addr);
      if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
               exp_q.push_back({b + AW'(i), data[8*i +: 8]});
               ref_mem[b + AW'(i)] = data[8*i +: 8];
            end
         end
      end else begin
         exp_rdata = ref_word(b);
      end
      @(negedge clk);
      ram_r_enable_i = rd;
      ram_w_enable_i = wr;
      ram_w_mask_i   = mask;
      ram_w_data_i   = data;
      ram_addr_i     = addr;
      done_at = 0;
      busy_n  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) idle_inputs();
         if (!wr && k <= 4) begin
            check("rd_addr", mem_addr_o, b + AW'(k - 1));
            check("rd_we", mem_we_o, 1'b0);
         end
         if (ram_busy_o) busy_n++;
         if (ram_done_o) begin
            done_at = k;
            break;
         end
      end
      check(wr ? "wr_done_cycle" : "rd_done_cycle", done_at, wr ? 5 : 6);
      check("busy_cycles", busy_n, wr ? 4 : 5);
      check("busy_at_done", ram_busy_o, 1'b0);
      check("rdata", ram_r_data_o, exp_rdata);
      @(negedge clk);
      check("done_one_cycle", ram_done_o, 1'b0);
      if (wr) begin
         compare_mem(b);
         check("strobes_left", exp_q.size(), 0);
      end
   endtask

   // Read request held high through DONE: the second read starts only at
   // the idle edge after DONE.
   task automatic held_read(input logic [31:0] addr);
      logic [12:0] got_busy, got_done, exp_busy, exp_done;
      exp_rdata = ref_word(base_of(addr));
      for (int k = 1; k <= 13; k++) begin
         exp_busy[k-1] = (k >= 1 && k <= 5) || (k >= 8 && k <= 12);
         exp_done[k-1] = (k == 6) || (k == 13);
      end
      @(negedge clk);
      ram_r_enable_i = 1'b1;
      ram_addr_i     = addr;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         got_busy[k-1] = ram_busy_o;
         got_done[k-1] = ram_done_o;
         if (k == 8) idle_inputs();
      end
      check("held_busy_pattern", got_busy, exp_busy);
      check("held_done_pattern", got_done, exp_done);
      check("held_rdata", ram_r_data_o, exp_rdata);
      @(negedge clk);
   endtask

   // Reset asserted during the cnt=2 write cycle.
   task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
      logic [AW-1:0] b;
      int dones;
      b = base_of(addr);
      // Lanes 0,1 complete; lane 2 is presented but cut off before its edge.
      for (int i = 0; i < 3; i++) exp_q.push_back({b + AW'(i), data[8*i +: 8]});
      for (int i = 0; i < 2; i++) ref_mem[b + AW'(i)] = data[8*i +: 8];
      @(negedge clk);
      ram_w_enable_i = 1'b1;
      ram_w_mask_i   = 4'hF;
      ram_w_data_i   = data;
      ram_addr_i     = addr;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", ram_busy_o, 1'b0);
      check("rst_done", ram_done_o, 1'b0);
      check("rst_we", mem_we_o, 1'b0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_dout", mem_dout_o, 0);
      check("rst_rdata", ram_r_data_o, 0);
      exp_rdata = 32'd0;
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ram_done_o) dones++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (ram_done_o) dones++;
      end
      check("rst_no_done", dones, 0);
      check("rst_strobes_left", exp_q.size(), 0);
      compare_mem(b);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      int mode;
      rst_n = 1'b0;
      idle_inputs();
      exp_rdata = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      check("reset_busy", ram_busy_o, 1'b0);
      check("reset_done", ram_done_o, 1'b0);
      check("reset_we", mem_we_o, 1'b0);
      check("reset_addr", mem_addr_o, 0);
      check("reset_rdata", ram_r_data_o, 0);
      rst_n = 1'b1;

      // Known read: bytes 11,22,33,44 at 0x100, request at unaligned 0x102.
      for (int i = 0; i < 4; i++) begin
         mem[32'h100 + i]     = 8'(8'h11 * (i + 1));
         ref_mem[32'h100 + i] = mem[32'h100 + i];
      end
      run_txn(1'b1, 1'b0, 32'h102, 4'h0, 32'h0);
      check("read_word_0x100", ram_r_data_o, 32'h4433_2211);

      // Single high-lane write; lower bytes untouched.
      run_txn(1'b0, 1'b1, 32'h203, 4'b1000, 32'hAAAA_AAAA);

      // Read and write together: the write wins, read data is unchanged.
      run_txn(1'b1, 1'b1, 32'h10, 4'b1111, 32'h0102_0304);
      check("rw_rdata_kept", ram_r_data_o, 32'h4433_2211);

      // Empty mask still walks four cycles without a strobe.
      run_txn(1'b0, 1'b1, 32'h420, 4'b0000, 32'h5555_5555);

      held_read(32'h100);

      // Top of memory: no wrap inside the word, plus upper address bits ignored.
      run_txn(1'b1, 1'b0, 32'hFFFE_0000 | 32'h1FFFE, 4'h0, 32'h0);
      run_txn(1'b0, 1'b1, 32'h1FFFF, 4'b1010, 32'hC0DE_F00D);
      run_txn(1'b1, 1'b0, 32'h1FFFC, 4'h0, 32'h0);

      reset_mid_write(32'h300, 32'hDEAD_BEEF);
      // First idle edge after reset release accepts a request.
      run_txn(1'b1, 1'b0, 32'h300, 4'h0, 32'h0);

      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 2);
         a    = $urandom;
         if (n % 8 == 0) a = {a[31:AW], {(AW-4){1'b1}}, a[3:0]};
         run_txn(mode != 1, mode != 0, a, 4'($urandom_range(0, 15)), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop if the sequence never completes.
   initial begin
      #500000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_ctrl
